// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter, stepped by an external baud tick.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_tick,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*DATA_W-1:0]   i_req_data,
    output logic [NREQ-1:0]          o_req_ack,
    output logic                     o_tick_sync,
    output logic                     o_tx,
    output logic                     o_busy,
    output logic [$clog2(NREQ)-1:0]  o_grant_id
);
    localparam int IDW = $clog2(NREQ);
    localparam int BW  = $clog2(DATA_W);

`ifdef UART_TX_ARB_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                        state;
    logic [NREQ-1:0][DATA_W-1:0]   req_data;
    logic [DATA_W-1:0]             shift;
    logic [BW-1:0]                 bit_idx;
    logic [IDW-1:0]                rr_ptr;
    logic [IDW-1:0]                cand;
    logic [IDW-1:0]                win_idx;
    logic [IDW-1:0]                win_next;
    logic                          win_found;

    assign req_data = i_req_data;

    // Walk from the far end back toward rr_ptr so the nearest valid index wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_next = IDW'((int'(win_idx) + 1) % NREQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shift       <= '0;
            bit_idx     <= '0;
            rr_ptr      <= '0;
            o_grant_id  <= '0;
            o_req_ack   <= '0;
            o_tick_sync <= 1'b0;
            o_busy      <= 1'b0;
            o_tx        <= 1'b1;
        end else begin
            o_req_ack   <= '0;
            o_tick_sync <= 1'b0;
            case (state)
                IDLE: begin
                    // Ticks are ignored here; the sync pulse restarts the divider for the start bit.
                    if (win_found) begin
                        shift       <= req_data[win_idx];
                        o_grant_id  <= win_idx;
                        rr_ptr      <= win_next;
                        o_req_ack   <= NREQ'(1) << win_idx;
                        o_tick_sync <= 1'b1;
                        o_busy      <= 1'b1;
                        o_tx        <= 1'b0;
                        state       <= START;
                    end
                end
                START: begin
                    if (i_tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        o_tx    <= shift[0];
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (bit_idx == BW'(DATA_W - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
                            state <= PAR;
                            o_tx  <= ^shift;
`else
                            state <= STOP;
                            o_tx  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            o_tx    <= shift[bit_idx + 1'b1];
                        end
                    end
                end
`ifdef UART_TX_ARB_PARITY_EN
                PAR: begin
                    if (i_tick) begin
                        state <= STOP;
                        o_tx  <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (i_tick) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_tx   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
